// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: bundles the Johnson code input stream and the decoded
// phase / integrity outputs of johnson_decoder.
// master = the side that sends codes and observes results; slave = the decoder.
interface johnson_decoder_if #(
  parameter int W = 4
) ();
  localparam int IW = $clog2(2 * W);

  logic [W-1:0]    jc_in;
  logic            jc_vld;
  logic [IW-1:0]   idx;
  logic [2*W-1:0]  onehot;
  logic            out_vld;
  logic            locked;
  logic            err_illegal;
  logic            err_seq;
  logic [7:0]      err_cnt;

  modport master (
    output jc_in, jc_vld,
    input  idx, onehot, out_vld, locked, err_illegal, err_seq, err_cnt
  );

  modport slave (
    input  jc_in, jc_vld,
    output idx, onehot, out_vld, locked, err_illegal, err_seq, err_cnt
  );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: samples a W-bit Johnson ring code each valid cycle, decodes
// it to a binary index and a one-hot phase, checks that the code is a legal
// Johnson pattern and the successor of the previous code, and tracks lock with
// a HUNT/LOCKED FSM. All outputs are registered one cycle after the sample.
// Optional feature macro: JDEC_ERRCNT_EN (saturating 8-bit error counter;
// when undefined err_cnt is tied to zero).
module johnson_decoder #(
  parameter int W          = 4,
  parameter int LOCK_CNT   = 2,
  parameter int ALLOW_HOLD = 0
) (
  input logic             clk,
  input logic             rst,
  johnson_decoder_if.slave bus
);
  localparam int IW = $clog2(2 * W);
  localparam int N  = 2 * W;
  localparam int CW = 4;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);
  localparam logic [CW-1:0] LOCK_TGT = CW'(LOCK_CNT);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            out_vld_q, out_vld_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_seq_q, err_seq_d;
  logic            prev_ok_q, prev_ok_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW:0]     ones;
  logic [IW:0]     edges;
  logic            code_legal;
  logic [IW-1:0]   code_idx;
  logic [IW-1:0]   exp_idx;
  logic            hold_ok;

  // Legality and index decode of the raw input code: a Johnson code has at
  // most one boundary between its run of ones and its run of zeros; codes
  // whose LSB is set (or all-zero) are in the filling half of the cycle.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + (IW + 1)'(bus.jc_in[i]);
    end
    for (int i = 0; i < W - 1; i++) begin
      edges = edges + (IW + 1)'(bus.jc_in[i] ^ bus.jc_in[i+1]);
    end
    code_legal = (edges <= (IW + 1)'(1));
    if (bus.jc_in[0] || (bus.jc_in == '0)) begin
      code_idx = IW'(ones);
    end else begin
      code_idx = IW'(N_EXT - ones);
    end
  end

  // Expected successor index of the last accepted code, wrapping 2W-1 -> 0.
  assign exp_idx = (idx_q == LAST_IDX) ? '0 : (idx_q + IW'(1));

  // A repeat of the previous index is tolerated only when holds are enabled.
  assign hold_ok = (ALLOW_HOLD != 0) && (code_idx == idx_q);

  // Next-state logic: decode, sequence check, good-run counter and lock FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    onehot_d      = onehot_q;
    out_vld_d     = bus.jc_vld;
    err_illegal_d = 1'b0;
    err_seq_d     = 1'b0;
    prev_ok_d     = prev_ok_q;
    cnt_d         = cnt_q;

    if (bus.jc_vld) begin
      if (!code_legal) begin
        err_illegal_d = 1'b1;
        onehot_d      = '0;
        prev_ok_d     = 1'b0;
        cnt_d         = '0;
        state_d       = HUNT;
      end else begin
        onehot_d  = N'(1) << code_idx;
        idx_d     = code_idx;
        prev_ok_d = 1'b1;
        if (prev_ok_q) begin
          if (code_idx == exp_idx) begin
            if (state_q == HUNT) begin
              if (cnt_q != '1) begin
                cnt_d = cnt_q + CW'(1);
              end
              if (cnt_d >= LOCK_TGT) begin
                state_d = LOCKED;
              end
            end
          end else if (!hold_ok) begin
            err_seq_d = 1'b1;
            cnt_d     = '0;
            state_d   = HUNT;
          end
        end else begin
          cnt_d = '0;
        end
      end
    end
  end

  // Register all state and outputs; reset wins over any simultaneous input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      onehot_q      <= '0;
      out_vld_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      prev_ok_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      onehot_q      <= onehot_d;
      out_vld_q     <= out_vld_d;
      err_illegal_q <= err_illegal_d;
      err_seq_q     <= err_seq_d;
      prev_ok_q     <= prev_ok_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.idx         = idx_q;
  assign bus.onehot      = onehot_q;
  assign bus.out_vld     = out_vld_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_seq     = err_seq_q;

`ifdef JDEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count every error pulse, saturating at 255, in the same output cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_illegal_d || err_seq_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: drives two johnson_decoder instances (ALLOW_HOLD=0 and
// ALLOW_HOLD=1) with the same stream and compares both against a reference
// model that decodes by looking the code up in the generated Johnson sequence.
// A hand-derived vector table additionally pins the ALLOW_HOLD=0 instance.
module tb_johnson_decoder;
  localparam int W    = 4;
  localparam int N    = 2 * W;
  localparam int LOCK = 2;
`ifdef JDEC_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  johnson_decoder_if #(.W(W)) bus0 ();
  johnson_decoder_if #(.W(W)) bus1 ();

  johnson_decoder #(.W(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  johnson_decoder #(.W(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Johnson sequence generated from the counter's next-state rule.
  logic [W-1:0] seq_tab [N];

  // Reference model state per instance (0: no hold, 1: hold allowed).
  int m_idx [2], m_oh [2], m_vld [2], m_lk [2], m_ill [2], m_sq [2];
  int m_ec [2], m_prev_ok [2], m_cnt [2];

  typedef struct packed {
    logic         r;
    logic         v;
    logic [W-1:0] code;
    logic [2:0]   idx;
    logic [N-1:0] oh;
    logic         vld;
    logic         lk;
    logic         ill;
    logic         sq;
  } vec_t;

  vec_t vecs [$];

  task automatic addVec(input logic r, input logic v, input logic [W-1:0] code,
                        input logic [2:0] idx, input logic [N-1:0] oh,
                        input logic vld, input logic lk, input logic ill,
                        input logic sq);
    vec_t e;
    e.r = r; e.v = v; e.code = code; e.idx = idx; e.oh = oh;
    e.vld = vld; e.lk = lk; e.ill = ill; e.sq = sq;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input int k, input bit hold_ok, input logic r,
                           input logic v, input logic [W-1:0] code);
    int pos;
    pos = -1;
    if (!r) begin
      m_idx[k] = 0; m_oh[k] = 0; m_vld[k] = 0; m_lk[k] = 0; m_ill[k] = 0;
      m_sq[k] = 0; m_ec[k] = 0; m_prev_ok[k] = 0; m_cnt[k] = 0;
      return;
    end
    m_ill[k] = 0;
    m_sq[k]  = 0;
    m_vld[k] = int'(v);
    if (!v) return;
    for (int i = 0; i < N; i++) begin
      if (seq_tab[i] == code) pos = i;
    end
    if (pos < 0) begin
      m_ill[k] = 1; m_oh[k] = 0; m_prev_ok[k] = 0; m_cnt[k] = 0; m_lk[k] = 0;
    end else begin
      m_oh[k] = 1 << pos;
      if (m_prev_ok[k] != 0) begin
        if (pos == (m_idx[k] + 1) % N) begin
          if (m_lk[k] == 0) begin
            m_cnt[k]++;
            if (m_cnt[k] >= LOCK) m_lk[k] = 1;
          end
        end else if (!(hold_ok && pos == m_idx[k])) begin
          m_sq[k] = 1; m_cnt[k] = 0; m_lk[k] = 0;
        end
      end else begin
        m_cnt[k] = 0;
      end
      m_idx[k]     = pos;
      m_prev_ok[k] = 1;
    end
    if (ERRCNT_EN && (m_ill[k] != 0 || m_sq[k] != 0) && m_ec[k] < 255) m_ec[k]++;
  endtask

  // Drive one input cycle on both instances, let the edge pass, update models.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] code);
    @(negedge clk);
    rst = r;
    bus0.jc_in = code; bus0.jc_vld = v;
    bus1.jc_in = code; bus1.jc_vld = v;
    @(posedge clk);
    #1;
    modelStep(0, 1'b0, r, v, code);
    modelStep(1, 1'b1, r, v, code);
  endtask

  task automatic checkOne(input string tag, input int k, input logic [2:0] idx,
                          input logic [N-1:0] oh, input logic vld, input logic lk,
                          input logic ill, input logic sq, input logic [7:0] ec);
    check($sformatf("%s.d%0d.idx", tag, k), 32'(idx), m_idx[k]);
    check($sformatf("%s.d%0d.onehot", tag, k), 32'(oh), m_oh[k]);
    check($sformatf("%s.d%0d.out_vld", tag, k), 32'(vld), m_vld[k]);
    check($sformatf("%s.d%0d.locked", tag, k), 32'(lk), m_lk[k]);
    check($sformatf("%s.d%0d.err_illegal", tag, k), 32'(ill), m_ill[k]);
    check($sformatf("%s.d%0d.err_seq", tag, k), 32'(sq), m_sq[k]);
    check($sformatf("%s.d%0d.err_cnt", tag, k), 32'(ec), m_ec[k]);
  endtask

  task automatic checkOutput(input string tag);
    checkOne(tag, 0, bus0.idx, bus0.onehot, bus0.out_vld, bus0.locked,
             bus0.err_illegal, bus0.err_seq, bus0.err_cnt);
    checkOne(tag, 1, bus1.idx, bus1.onehot, bus1.out_vld, bus1.locked,
             bus1.err_illegal, bus1.err_seq, bus1.err_cnt);
  endtask

  initial begin
    logic [W-1:0] q;
    int           pos;
    int           sel;
    logic [W-1:0] code;
    logic         r, v;
    int           final_ec;

    rst = 1'b0;
    bus0.jc_in = '0; bus0.jc_vld = 1'b0;
    bus1.jc_in = '0; bus1.jc_vld = 1'b0;

    q = '0;
    for (int i = 0; i < N; i++) begin
      seq_tab[i] = q;
      q = {q[W-2:0], ~q[W-1]};
    end

    // r v code idx onehot vld lk ill sq (expected values for ALLOW_HOLD=0)
    addVec(0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    addVec(0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 8'h01, 1, 0, 0, 0);
    addVec(1, 1, 4'b0001, 1, 8'h02, 1, 0, 0, 0);
    addVec(1, 1, 4'b0011, 2, 8'h04, 1, 1, 0, 0);
    addVec(1, 1, 4'b0111, 3, 8'h08, 1, 1, 0, 0);
    addVec(1, 1, 4'b1111, 4, 8'h10, 1, 1, 0, 0);
    addVec(1, 1, 4'b1110, 5, 8'h20, 1, 1, 0, 0);
    addVec(1, 1, 4'b1100, 6, 8'h40, 1, 1, 0, 0);
    addVec(1, 1, 4'b1000, 7, 8'h80, 1, 1, 0, 0);
    addVec(1, 1, 4'b0000, 0, 8'h01, 1, 1, 0, 0);
    addVec(1, 1, 4'b0101, 0, 8'h00, 1, 0, 1, 0);
    addVec(1, 1, 4'b0011, 2, 8'h04, 1, 0, 0, 0);
    addVec(1, 1, 4'b0111, 3, 8'h08, 1, 0, 0, 0);
    addVec(1, 1, 4'b1111, 4, 8'h10, 1, 1, 0, 0);
    addVec(1, 1, 4'b0001, 1, 8'h02, 1, 0, 0, 1);
    addVec(1, 1, 4'b0111, 3, 8'h08, 1, 0, 0, 1);
    addVec(1, 1, 4'b0111, 3, 8'h08, 1, 0, 0, 1);
    addVec(1, 1, 4'b1111, 4, 8'h10, 1, 0, 0, 0);
    addVec(1, 1, 4'b1110, 5, 8'h20, 1, 1, 0, 0);
    addVec(1, 0, 4'b0101, 5, 8'h20, 0, 1, 0, 0);
    addVec(1, 0, 4'b0101, 5, 8'h20, 0, 1, 0, 0);
    addVec(1, 0, 4'b0101, 5, 8'h20, 0, 1, 0, 0);
    addVec(1, 1, 4'b1100, 6, 8'h40, 1, 1, 0, 0);
    addVec(0, 1, 4'b1000, 0, 8'h00, 0, 0, 0, 0);
    addVec(1, 1, 4'b1000, 7, 8'h80, 1, 0, 0, 0);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].r, vecs[n].v, vecs[n].code);
      checkOutput($sformatf("vec%0d", n));
      check($sformatf("tbl%0d.idx", n), 32'(bus0.idx), 32'(vecs[n].idx));
      check($sformatf("tbl%0d.onehot", n), 32'(bus0.onehot), 32'(vecs[n].oh));
      check($sformatf("tbl%0d.out_vld", n), 32'(bus0.out_vld), 32'(vecs[n].vld));
      check($sformatf("tbl%0d.locked", n), 32'(bus0.locked), 32'(vecs[n].lk));
      check($sformatf("tbl%0d.err_illegal", n), 32'(bus0.err_illegal), 32'(vecs[n].ill));
      check($sformatf("tbl%0d.err_seq", n), 32'(bus0.err_seq), 32'(vecs[n].sq));
    end

    // Relock, then repeat a code: tolerated only by the hold-enabled instance.
    applyStimulus(1, 1, 4'b0000); checkOutput("relock0");
    applyStimulus(1, 1, 4'b0001); checkOutput("relock1");
    applyStimulus(1, 1, 4'b0011); checkOutput("hold0");
    applyStimulus(1, 1, 4'b0011); checkOutput("hold1");
    check("hold.d1.err_seq", 32'(bus1.err_seq), 0);
    check("hold.d1.locked", 32'(bus1.locked), 1);
    check("hold.d0.err_seq", 32'(bus0.err_seq), 1);
    check("hold.d0.locked", 32'(bus0.locked), 0);

    // Randomized stream: mostly successors, with holds, skips, junk, gaps, resets.
    pos = 0;
    for (int c = 0; c < 500; c++) begin
      sel = int'($urandom_range(0, 99));
      r = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 9) < 8);
      if (sel < 70) begin
        pos = (pos + 1) % N;
        code = seq_tab[pos];
      end else if (sel < 80) begin
        code = seq_tab[pos];
      end else if (sel < 90) begin
        pos = (pos + 2 + int'($urandom_range(0, 4))) % N;
        code = seq_tab[pos];
      end else begin
        code = W'($urandom);
      end
      applyStimulus(r, v, code);
      checkOutput($sformatf("rnd%0d", c));
    end

    // Long run of illegal codes to drive the error counter into saturation.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1, 1, (c % 2 == 0) ? 4'b0101 : 4'b1010);
      checkOutput($sformatf("sat%0d", c));
    end
    final_ec = ERRCNT_EN ? 255 : 0;
    check("sat.d0.err_cnt", 32'(bus0.err_cnt), final_ec);
    check("sat.d1.err_cnt", 32'(bus1.err_cnt), final_ec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive-side companion to the 4-bit Johnson counter: samples a Johnson-coded ring state each cycle and decodes it to a binary index and a one-hot phase.
- Checks that every code is a legal Johnson pattern and is the successor of the previous code.
- Runs a HUNT/LOCKED tracking FSM.
- Sits downstream of any Johnson counter as a phase decoder and integrity monitor.

Parameters:
- W, 4, Johnson register width; sequence length 2W. W ≥ 2.
- LOCK_CNT, 2, consecutive good successor codes required to go HUNT→LOCKED. Range 1..15.
- ALLOW_HOLD, 0, 1 = a repeated identical legal code is not a sequence error.
- IW, $clog2(2*W), index width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- jc_in  in  W  Johnson code; encoding follows next = {q[W-2:0], ~q[W-1]}
- jc_vld  in  1  jc_in valid this cycle
- idx  out  IW  decoded index 0..2W-1
- onehot  out  2W  bit idx set; all zero when code illegal
- out_vld  out  1  registered copy of jc_vld
- locked  out  1  FSM in LOCKED
- err_illegal  out  1  1-cycle pulse: sampled code illegal
- err_seq  out  1  1-cycle pulse: legal code but not expected successor
- err_cnt  out  8  saturating error count (macro-dependent, see below)

Behaviour:
- Reset (rst=0 at posedge) forces all outputs to 0: idx, onehot, out_vld, locked, err_* and err_cnt. FSM→HUNT; prev_ok=0; good-run counter=0.
- Latency: all outputs registered, 1 cycle after the jc_in/jc_vld sample.
- When jc_vld=0: out_vld=0, err pulses 0, idx/onehot/locked/prev state hold.
- Legality: code is legal iff the count of adjacent bit changes (q[i]≠q[i+1], i=0..W-2) ≤ 1.
- Index decode for a legal code:
  - if q[0]=1 or q=0: idx = popcount(q)
  - else: idx = 2W − popcount(q)
  - W=4 reference values: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
- Illegal code handling:
  - idx holds its previous value, onehot=0, err_illegal=1.
  - prev_ok cleared, good-run counter cleared.
- Sequence check applies only when prev_ok=1:
  - Expected index = (prev_idx+1) mod 2W; wrap 2W−1→0 is legal.
  - Mismatch → err_seq=1, good-run counter cleared.
  - Same index with ALLOW_HOLD=1 → no error, counter unchanged.
  - After the check, prev_idx updates to the new index and prev_ok=1.
- err_illegal and err_seq are never both 1 in the same cycle.
- FSM:
  - HUNT: each legal, in-sequence valid code increments the good-run counter. The first legal code after prev_ok=0 counts 0. Counter reaching LOCK_CNT → LOCKED, with locked=1 registered in that same output cycle.
  - LOCKED: any err_illegal or err_seq → HUNT, locked=0 in that output cycle, counter cleared.
- Reset mid-operation wins over any simultaneous valid input.

Optional Feature:
- Macro JDEC_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each cycle where err_illegal or err_seq is 1, saturates at 255, and clears only on reset.
- Undefined: no counter logic; err_cnt tied to 0.

Test Plan:
- Reset then clean sequence: rst=0 for 2 cycles, then feed 0000,0001,0011,0111,1111,1110,1100,1000,0000 with jc_vld=1 → idx 0..7,0 one cycle later; onehot=1<<idx; no errors; locked=1 on the third output (after 2 good successors).
- Illegal code while locked: after lock, inject 0101 → onehot=0, idx held, err_illegal=1 for one cycle, locked=0; then 0011,0111,1111 → relock on the third.
- Skip: after lock, 0001 then 0111 → err_seq=1, idx=3, locked=0. With ALLOW_HOLD=0, 0111,0111 → err_seq.
- Hold and gaps: ALLOW_HOLD=1 with 1110 twice → no error, locked stays 1. jc_vld=0 for 3 cycles → out_vld=0, outputs hold, next 1100 accepted as successor.
- Reset mid-lock: assert rst=0 while locked with valid input → next cycle all outputs 0, state HUNT.
- JDEC_ERRCNT_EN defined: 300 alternating 0101/1010 codes → err_cnt saturates at 255. Undefined → err_cnt stays 0.
